// File: rtl/ibex_dummy_instr_checker.sv
`default_nettype none
// ============================================================================
// Module      : ibex_dummy_instr_checker
// Description : Retire-side monitor for dummy instructions. Tracks issued
//               dummies in an in-order FIFO and checks them at writeback.
//               Optional statistics counters: IBEX_DUMMY_CHK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_dummy_instr_checker #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     chk_en_i,
    input  logic                     issue_valid_i,
    input  logic [31:0]              issue_instr_i,
    input  logic                     flush_i,
    input  logic                     retire_valid_i,
    input  logic                     retire_is_dummy_i,
    input  logic [31:0]              retire_instr_i,
    input  logic                     retire_rd_we_i,
    output logic                     chk_err_o,
    output logic                     chk_err_sticky_o,
    output logic [2:0]               chk_err_code_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef IBEX_DUMMY_CHK_STATS_EN
    ,
    output logic [CNT_W-1:0]         dummy_retired_cnt_o,
    output logic [CNT_W-1:0]         dummy_flushed_cnt_o
`endif
);

    localparam int unsigned     c_aw     = $clog2(DEPTH);
    localparam int unsigned     c_tw     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_aw:0]   c_full   = (c_aw + 1)'(DEPTH);
    localparam logic [c_tw-1:0] c_to_max = c_tw'(TIMEOUT_CYC);

    localparam logic [2:0] c_code_none      = 3'd0;
    localparam logic [2:0] c_code_overflow  = 3'd1;
    localparam logic [2:0] c_code_mismatch  = 3'd2;
    localparam logic [2:0] c_code_underflow = 3'd3;
    localparam logic [2:0] c_code_ill_enc   = 3'd4;
    localparam logic [2:0] c_code_rd_write  = 3'd5;
    localparam logic [2:0] c_code_timeout   = 3'd6;

    logic [31:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [c_tw-1:0] r_to_cnt;
    logic            r_err;
    logic            r_sticky;
    logic [2:0]      r_code;

    logic        w_active;
    logic        w_flush;
    logic        w_push_req;
    logic        w_pop_req;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head;
    logic        w_underflow;
    logic        w_mismatch;
    logic        w_ill_enc;
    logic        w_rd_write;
    logic        w_overflow;
    logic        w_to_inc;
    logic        w_timeout;
    logic        w_any_err;
    logic [2:0]  w_code;

    function automatic logic enc_legal(input logic [31:0] instr);
        logic [9:0] f;
        f = {instr[31:25], instr[14:12]};
        return (instr[6:0] == 7'h33) && (instr[11:7] == 5'd0) &&
               ((f == 10'b0000000_000) || (f == 10'b0000001_000) ||
                (f == 10'b0000001_100) || (f == 10'b0000000_111));
    endfunction

    // Disable freezes everything, including flush handling.
    assign w_active   = chk_en_i & ~flush_i;
    assign w_flush    = chk_en_i & flush_i;
    assign w_push_req = w_active & issue_valid_i;
    assign w_pop_req  = w_active & retire_valid_i & retire_is_dummy_i;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);
    assign w_head  = r_mem[r_rd_ptr];

    // No bypass from issue to retire: a pop on an empty FIFO is an underflow.
    assign w_pop  = w_pop_req & ~w_empty;
    assign w_push = w_push_req & (~w_full | w_pop);

    assign w_underflow = w_pop_req & w_empty;
    assign w_mismatch  = w_pop & (retire_instr_i != w_head);
    assign w_ill_enc   = w_pop_req & ~enc_legal(retire_instr_i);
    assign w_rd_write  = w_pop_req & retire_rd_we_i;
    assign w_overflow  = w_push_req & w_full & ~w_pop;

    assign w_to_inc  = w_active & ~w_empty & ~w_pop & (r_to_cnt != c_to_max);
    assign w_timeout = w_to_inc & (r_to_cnt == c_to_max - 1'b1);

    assign w_any_err = w_underflow | w_mismatch | w_ill_enc | w_rd_write |
                       w_overflow | w_timeout;

    always_comb begin
        w_code = c_code_none;
        if (w_underflow)     w_code = c_code_underflow;
        else if (w_mismatch) w_code = c_code_mismatch;
        else if (w_ill_enc)  w_code = c_code_ill_enc;
        else if (w_rd_write) w_code = c_code_rd_write;
        else if (w_overflow) w_code = c_code_overflow;
        else if (w_timeout)  w_code = c_code_timeout;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= issue_instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
        end else if (w_flush || w_pop || w_empty) begin
            r_to_cnt <= '0;
        end else if (w_to_inc) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err    <= 1'b0;
            r_code   <= c_code_none;
            r_sticky <= 1'b0;
        end else begin
            r_err    <= w_any_err;
            r_code   <= w_code;
            r_sticky <= r_sticky | w_any_err;
        end
    end

    assign chk_err_o        = r_err;
    assign chk_err_code_o   = r_code;
    assign chk_err_sticky_o = r_sticky;
    assign occupancy_o      = r_count;

`ifdef IBEX_DUMMY_CHK_STATS_EN
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_flu_cnt;
    logic [CNT_W:0]   w_flu_sum;

    assign w_flu_sum = {1'b0, r_flu_cnt} + (CNT_W + 1)'(r_count);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ret_cnt <= '0;
            r_flu_cnt <= '0;
        end else begin
            if (w_pop && (r_ret_cnt != '1)) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
            if (w_flush) begin
                r_flu_cnt <= w_flu_sum[CNT_W] ? '1 : w_flu_sum[CNT_W-1:0];
            end
        end
    end

    assign dummy_retired_cnt_o = r_ret_cnt;
    assign dummy_flushed_cnt_o = r_flu_cnt;
`endif

endmodule
`default_nettype wire
